// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, mstatus bit positions and fixed values for csr_file
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [31:0] MISA_VAL    = 32'h4000_0100;
   // mtvec and mepc never hold the two low bits
   localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit free-running counter with per-half software write
module csr_counter64 (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_inc,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [31:0] i_wdata,
   output logic [63:0] o_count
);

   logic [63:0] r_count;

   // a software write replaces one half and suppresses that cycle's increment
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= 64'd0;
      end else if (i_wr_lo || i_wr_hi) begin
         if (i_wr_lo) r_count[31:0]  <= i_wdata;
         if (i_wr_hi) r_count[63:32] <= i_wdata;
      end else if (i_inc) begin
         r_count <= r_count + 64'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file; 64-bit counters built only with CSR_COUNTERS_EN
module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [11:0] i_rd_addr,
   output logic [31:0] o_rd_data,
   output logic        o_rd_illegal,
   input  logic        i_wr_en,
   input  logic [11:0] i_wr_addr,
   input  logic [31:0] i_wr_data,
   input  logic        i_instret_inc,
   input  logic        i_trap_en,
   input  logic [31:0] i_trap_pc,
   input  logic [31:0] i_trap_cause,
   input  logic [31:0] i_trap_tval,
   input  logic        i_mret_en,
   output logic [31:0] o_mtvec_out,
   output logic [31:0] o_mepc_out,
   output logic        o_mie_global
);

   logic        r_mstatus_mie;
   logic        r_mstatus_mpie;
   logic [31:0] r_mie;
   logic [31:0] r_mtvec;
   logic [31:0] r_mscratch;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_mtval;
   logic [31:0] w_mstatus;

   // later assignments win: software write, then mret, then trap
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= 32'd0;
         r_mtvec        <= RESET_MTVEC & ALIGN4_MASK;
         r_mscratch     <= 32'd0;
         r_mepc         <= 32'd0;
         r_mcause       <= 32'd0;
         r_mtval        <= 32'd0;
      end else begin
         if (i_wr_en) begin
            case (i_wr_addr)
               CSR_MSTATUS: begin
                  r_mstatus_mie  <= i_wr_data[MSTATUS_MIE];
                  r_mstatus_mpie <= i_wr_data[MSTATUS_MPIE];
               end
               CSR_MIE:      r_mie      <= i_wr_data;
               CSR_MTVEC:    r_mtvec    <= i_wr_data & ALIGN4_MASK;
               CSR_MSCRATCH: r_mscratch <= i_wr_data;
               CSR_MEPC:     r_mepc     <= i_wr_data & ALIGN4_MASK;
               CSR_MCAUSE:   r_mcause   <= i_wr_data;
               CSR_MTVAL:    r_mtval    <= i_wr_data;
               default: ;
            endcase
         end
         if (i_mret_en) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end
         if (i_trap_en) begin
            r_mepc         <= i_trap_pc & ALIGN4_MASK;
            r_mcause       <= i_trap_cause;
            r_mtval        <= i_trap_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [63:0] w_cycle;
   logic [63:0] w_instret;

   csr_counter64 u_mcycle (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (1'b1),
      .i_wr_lo (i_wr_en && (i_wr_addr == CSR_MCYCLE)),
      .i_wr_hi (i_wr_en && (i_wr_addr == CSR_MCYCLEH)),
      .i_wdata (i_wr_data),
      .o_count (w_cycle)
   );

   csr_counter64 u_minstret (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (i_instret_inc),
      .i_wr_lo (i_wr_en && (i_wr_addr == CSR_MINSTRET)),
      .i_wr_hi (i_wr_en && (i_wr_addr == CSR_MINSTRETH)),
      .i_wdata (i_wr_data),
      .o_count (w_instret)
   );
`else
   logic w_unused_instret_inc;
   assign w_unused_instret_inc = i_instret_inc;
`endif

   // mstatus view: MPP hard-wired to machine mode, only MIE/MPIE live
   always_comb begin
      w_mstatus                                = 32'd0;
      w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      w_mstatus[MSTATUS_MPIE]                  = r_mstatus_mpie;
      w_mstatus[MSTATUS_MIE]                   = r_mstatus_mie;
   end

   // combinational read port; unknown addresses read 0 and flag illegal
   always_comb begin
      o_rd_data    = 32'd0;
      o_rd_illegal = 1'b0;
      case (i_rd_addr)
         CSR_MSTATUS:  o_rd_data = w_mstatus;
         CSR_MISA:     o_rd_data = MISA_VAL;
         CSR_MIE:      o_rd_data = r_mie;
         CSR_MTVEC:    o_rd_data = r_mtvec;
         CSR_MSCRATCH: o_rd_data = r_mscratch;
         CSR_MEPC:     o_rd_data = r_mepc;
         CSR_MCAUSE:   o_rd_data = r_mcause;
         CSR_MTVAL:    o_rd_data = r_mtval;
         CSR_MHARTID:  o_rd_data = HART_ID;
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE,    CSR_CYCLE:    o_rd_data = w_cycle[31:0];
         CSR_MCYCLEH,   CSR_CYCLEH:   o_rd_data = w_cycle[63:32];
         CSR_MINSTRET,  CSR_INSTRET:  o_rd_data = w_instret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: o_rd_data = w_instret[63:32];
`endif
         default:      o_rd_illegal = 1'b1;
      endcase
   end

   assign o_mtvec_out  = r_mtvec;
   assign o_mepc_out   = r_mepc;
   assign o_mie_global = r_mstatus_mie;

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control and status register file for the RV32I 5-stage pipeline; the storage end of the CSR read-modify-write path. Provides the combinational read of the old CSR value to the execute stage and commits the new value computed there at writeback. Also owns trap entry/`mret` state updates and, optionally, the 64-bit cycle and retired-instruction counters.

## Interface
- `RESET_MTVEC`, 32'h0000_0000, reset value of `mtvec` (bits 1:0 forced 0)
- `HART_ID`, 0, value returned by `mhartid`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rd_addr`  in  12  CSR address being read (execute stage)
- `rd_data`  out  32  current value of `rd_addr`; 0 if unimplemented
- `rd_illegal`  out  1  `rd_addr` not implemented
- `wr_en`  in  1  commit CSR write (writeback stage)
- `wr_addr`  in  12  CSR address to write
- `wr_data`  in  32  new CSR value
- `instret_inc`  in  1  one instruction retired this cycle
- `trap_en`  in  1  take trap this cycle
- `trap_pc`, `trap_cause`, `trap_tval`  in  32 each  values captured on trap
- `mret_en`  in  1  execute `mret` this cycle
- `mtvec_out`, `mepc_out`  out  32 each  trap target / return target to fetch
- `mie_global`  out  1  `mstatus.MIE`

## Operation
- Implemented: `mstatus` 0x300 (MIE bit 3, MPIE bit 7 writable; MPP bits 12:11 read 2'b11, other bits read 0), `misa` 0x301 RO 32'h4000_0100, `mie` 0x304, `mtvec` 0x305, `mscratch` 0x340, `mepc` 0x341, `mcause` 0x342, `mtval` 0x343, `mhartid` 0xF14 RO.
- `mtvec` and `mepc` bits 1:0 always stored as 0.
- Writes to RO or unimplemented addresses are silently dropped; `rd_illegal` is purely a read-side flag.
- Trap: `mepc`<=`trap_pc`, `mcause`<=`trap_cause`, `mtval`<=`trap_tval`, MPIE<=MIE, MIE<=0.
- `mret`: MIE<=MPIE, MPIE<=1.
- Priority in one cycle: `trap_en` > `mret_en` > `wr_en`; a lower-priority update to a register the higher one touches is dropped; writes to untouched registers (e.g. `mscratch`) still commit.
- Reset: all writable CSRs 0 except `mtvec`=`RESET_MTVEC`; counters 0; `rd_illegal` reflects `rd_addr` only.

## Timing
- Read fully combinational, 0 cycles; no write-to-read bypass: a write at edge N is visible on `rd_data` after edge N.
- All updates take effect on the rising edge; `mtvec_out`/`mepc_out`/`mie_global` are register outputs.
- Reset asserted mid-operation discards any same-cycle write/trap immediately.

## Configuration
- `CSR_COUNTERS_EN` defined: `mcycle` 0xB00/`mcycleh` 0xB80, `minstret` 0xB02/`minstreth` 0xB82 (RW), `cycle` 0xC00/`cycleh` 0xC80, `instret` 0xC02/`instreth` 0xC82 (RO aliases). `mcycle` +1 every cycle; `minstret` +1 when `instret_inc`. 64-bit, carry low->high, wrap all-ones->0. Software write to either half replaces that half and suppresses the increment that cycle (other half unchanged, no carry).
- Not defined: counter addresses unimplemented (`rd_illegal`=1, read 0), no counter flops.

## Structure
- Package `csr_pkg`: CSR address localparams, `mstatus` bit indices (MIE, MPIE, MPP), `MISA_VAL`.
- Sub-module `csr_counter64`: 64-bit counter with `inc`, `wr_lo`, `wr_hi`, `wdata`; instantiated twice under `CSR_COUNTERS_EN`.

## Test plan
- Reset, `RESET_MTVEC`=32'h100 -> `mtvec_out`=32'h100, `rd_addr`=0x300 reads 32'h0000_1800, `rd_addr`=0x123 -> `rd_illegal`=1, `rd_data`=0.
- Write `mtvec`=32'h8000_0007 -> next cycle reads 32'h8000_0004; write `misa`=0 -> still 32'h4000_0100.
- MIE=1, `trap_en` pc=32'h44 cause=11 with same-cycle `wr_en` to `mepc`=32'h99 -> `mepc`=32'h44, `mcause`=11, MIE=0, MPIE=1; then `mret_en` -> MIE=1, MPIE=1.
- `mret_en` and `wr_en` `mscratch`=32'hA5 same cycle -> both applied.
- (`CSR_COUNTERS_EN`) write `mcycle`=32'hFFFF_FFFF -> next two reads 0xB00=0, 0xB80=1 after carry; `instret_inc` with write `minstret`=5 -> reads 5.
- (no macro) read 0xC00 -> `rd_illegal`=1, `rd_data`=0.
